// File: rtl/hamming_dec_arbiter.sv
// Two-channel round-robin front end sharing one Hamming(7,4) corrector, with a registered one-entry output stage.
// Optional per-channel corrected-error counters are enabled with the HAMDEC_ERRCNT_EN macro.
module hamming_dec_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [6:0]       in0_code,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [6:0]       in1_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_src,
    output logic [2:0]       out_syndrome,
    output logic             out_err
`ifdef HAMDEC_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1,
    input  logic             err_clr
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state, state_next;
    logic       lg;
    logic       load, any_req, grant, xfer;
    logic [6:0] code, fixed;
    logic [2:0] syn;

    // grant is only meaningful when any_req; with both valid the channel not served last wins
    always_comb begin
        any_req   = in0_valid | in1_valid;
        grant     = (in0_valid & in1_valid) ? ~lg : in1_valid;
        load      = (state == EMPTY) | out_ready;
        xfer      = load & any_req;
        in0_ready = xfer & ~grant;
        in1_ready = xfer & grant;
    end

    always_comb begin
        code   = grant ? in1_code : in0_code;
        syn[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
        syn[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
        syn[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
        fixed  = code;
        if (syn != 3'd0) begin
            fixed = code ^ (7'd1 << (syn - 3'd1));
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (any_req) state_next = FULL;
            FULL:    if (out_ready && !any_req) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign out_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            lg           <= 1'b1;
            out_data     <= 4'd0;
            out_src      <= 1'b0;
            out_syndrome <= 3'd0;
            out_err      <= 1'b0;
        end else begin
            state <= state_next;
            if (xfer) begin
                out_data     <= {fixed[6], fixed[5], fixed[4], fixed[2]};
                out_src      <= grant;
                out_syndrome <= syn;
                out_err      <= (syn != 3'd0);
                lg           <= grant;
            end
        end
    end

`ifdef HAMDEC_ERRCNT_EN
    // clear outranks a same-cycle increment; counts stick at all-ones
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_cnt0 <= '0;
            err_cnt1 <= '0;
        end else if (xfer && (syn != 3'd0)) begin
            if (grant) begin
                if (err_cnt1 != '1) err_cnt1 <= err_cnt1 + CNT_W'(1);
            end else begin
                if (err_cnt0 != '1) err_cnt0 <= err_cnt0 + CNT_W'(1);
            end
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
